// File: rtl/imem_loader_if.sv
// Upstream byte-stream handshake carrying the boot image into imem_loader.
// A byte transfers on a rising clock edge when byte_valid and byte_ready are both high.
interface imem_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_valid, output byte_data, input byte_ready);
    modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into 32-bit
// instruction-memory writes, then releases the core from reset once the image verifies.
module imem_loader #(
    parameter int ADDR_W = 10  // supported range 3..18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        bs,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                cpu_rst_n,
    output logic                done,
    output logic                error
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << (ADDR_W - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t      state;
    logic        ready_q;
    logic [15:0] len_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic [7:0]  csum;

    logic        accept;
    logic [15:0] len_next;

    assign bs.byte_ready = ready_q;
    assign accept        = bs.byte_valid && ready_q;
    assign len_next      = {bs.byte_data, len_words[7:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ready_q    <= 1'b0;
            len_words  <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse; it only re-arms on a completed word.
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_LEN_LO;
                        ready_q   <= 1'b1;
                        len_words <= '0;
                        word_idx  <= '0;
                        byte_cnt  <= '0;
                        word_buf  <= '0;
                        csum      <= '0;
                        cpu_rst_n <= 1'b0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_words[7:0] <= bs.byte_data;
                        state          <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_words[15:8] <= bs.byte_data;
                        if (len_next == 16'd0) begin
                            state <= S_CHK;
                        end else if ({1'b0, len_next} > MAX_WORDS) begin
                            state   <= S_ERR;
                            ready_q <= 1'b0;
                            error   <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum     <= csum ^ bs.byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= bs.byte_data;
                            2'd1: word_buf[15:8]  <= bs.byte_data;
                            2'd2: word_buf[23:16] <= bs.byte_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= ADDR_W'({word_idx, 2'b00});
                                imem_wdata <= {bs.byte_data, word_buf};
                                word_idx   <= word_idx + 16'd1;
                                if (word_idx == len_words - 16'd1) begin
                                    state <= S_CHK;
                                end
                            end
                        endcase
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (bs.byte_data == csum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
